beta_dmem_timer: RTL



---
 rtl/beta_dmem_timer.sv | 105 ++++++++++
 1 files changed

// File: rtl/beta_dmem_timer.sv
// Data-memory responder for the BETA load/store port with a memory-mapped interval timer.
// Loads are combinational; stores and timer updates commit on the rising CLK edge.
module beta_dmem_timer #(
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] MA,
   input  logic        MOE,
   input  logic        MWR,
   input  logic [31:0] MWD,
   output logic [31:0] MRD,
   output logic        IRQ
);

   localparam int unsigned Words = 2 ** DEPTH_LOG2;

   logic [31:0] mem [Words];

   logic [31:0] count_q, count_d;
   logic [31:0] reload_q, reload_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic        exp_q, exp_d;

   logic                  io_sel;
   logic [DEPTH_LOG2-1:0] ram_idx;
   logic                  wr_count, wr_reload, wr_ctrl, wr_status;
   logic                  en, ar, expire;
   logic [31:0]           io_rdata;
   logic                  unused_ma;

   assign io_sel    = (MA[31:28] == 4'hF);
   assign ram_idx   = MA[DEPTH_LOG2+1:2];
   assign unused_ma = ^{MA[1:0], MA[27:DEPTH_LOG2+2]};

   assign wr_count  = MWR && io_sel && (MA[3:2] == 2'd0);
   assign wr_reload = MWR && io_sel && (MA[3:2] == 2'd1);
   assign wr_ctrl   = MWR && io_sel && (MA[3:2] == 2'd2);
   assign wr_status = MWR && io_sel && (MA[3:2] == 2'd3);

   assign en     = ctrl_q[0];
   assign ar     = ctrl_q[2];
   assign expire = en && (count_q == 32'd1);

   always_comb begin
      count_d = count_q;
      if (wr_count) begin
         count_d = MWD;
      end else if (en) begin
         if (count_q == 32'd1) begin
            // reload_q is the pre-write value, so a same-cycle RELOAD write is not used here
            count_d = ar ? reload_q : 32'd0;
         end else if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
         end
      end
   end

   always_comb begin
      reload_d = wr_reload ? MWD : reload_q;
      ctrl_d   = wr_ctrl ? MWD[2:0] : ctrl_q;
      exp_d    = exp_q;
      if (expire) begin
         exp_d = 1'b1;
      end else if (wr_status && MWD[0]) begin
         exp_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         count_q  <= 32'd0;
         reload_q <= 32'd0;
         ctrl_q   <= 3'd0;
         exp_q    <= 1'b0;
      end else begin
         count_q  <= count_d;
         reload_q <= reload_d;
         ctrl_q   <= ctrl_d;
         exp_q    <= exp_d;
      end
   end

   // RAM is deliberately left out of reset; only the write is gated.
   always_ff @(posedge CLK) begin
      if (!RESET && MWR && !io_sel) begin
         mem[ram_idx] <= MWD;
      end
   end

   always_comb begin
      io_rdata = 32'd0;
      unique case (MA[3:2])
         2'd0: io_rdata = count_q;
         2'd1: io_rdata = reload_q;
         2'd2: io_rdata = {29'd0, ctrl_q};
         2'd3: io_rdata = {31'd0, exp_q};
         default: io_rdata = 32'd0;
      endcase
   end

   assign MRD = MOE ? (io_sel ? io_rdata : mem[ram_idx]) : 32'd0;
   assign IRQ = exp_q & ctrl_q[1];

endmodule
